// File: rtl/spi_master_2ss_pkg.sv
// Shared types and helpers for the two-slave SPI master.
// Holds the FSM encoding, the SPI mode constant and the slave-select decode.
package spi_master_2ss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  // Returns {ss2, ss1}; at most one select is ever low.
  function automatic logic [1:0] ss_decode(
    input logic active,
    input logic sel
  );
    logic [1:0] r;
    r = 2'b11;
    if (active) r = sel ? 2'b01 : 2'b10;
    return r;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: divides clk into a CPOL=0 sclk while enabled.
// rise_p/fall_p flag the cycle whose closing edge toggles the registered sclk.
module spi_sclk_gen
  import spi_master_2ss_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_p,
  output logic fall_p
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic CPOL = SPI_MODE0[1];

  logic [CW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          wrap;

  assign wrap   = en && (div_q == DIV_LAST);
  assign rise_p = wrap && (sclk_q == CPOL);
  assign fall_p = wrap && (sclk_q != CPOL);
  assign sclk   = sclk_q;

  // Next divider count and sclk level; idle parks sclk at CPOL.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en) begin
      div_d  = '0;
      sclk_d = CPOL;
    end else if (wrap) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + 1'b1;
    end
  end

  // Divider and sclk registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= CPOL;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_2ss.sv
// SPI mode-0 master with two active-low slave selects.
// One full-duplex MSB-first transfer per accepted start pulse.
module spi_master_2ss
  import spi_master_2ss_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              slave_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              ss1,
  output logic              ss2
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rxs_q, rxs_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mosi_q, mosi_d;
  logic              ss1_q, ss1_d;
  logic              ss2_q, ss2_d;
  logic              sck_en, rise_p, fall_p;
  logic              cnt_last;

  assign sck_en   = (state_q == ST_SHIFT);
  assign cnt_last = (cnt_q == CNT_LAST);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (sck_en),
    .sclk   (sclk),
    .rise_p (rise_p),
    .fall_p (fall_p)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_q;
  assign mosi    = mosi_q;
  assign ss1     = ss1_q;
  assign ss2     = ss2_q;

  // Transfer sequencing: next state, datapath and select decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rxs_d   = rxs_q;
    rx_d    = rx_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mosi_d  = mosi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_d    = tx_data;
          sel_d   = slave_sel;
          rxs_d   = '0;
          mosi_d  = tx_data[DATA_W-1];
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise_p) rxs_d = {rxs_q[DATA_W-2:0], miso};
        if (fall_p) begin
          if (bit_q == BIT_LAST) begin
            state_d = ST_HOLD;
          end else begin
            bit_d  = bit_q + 1'b1;
            tx_d   = {tx_q[DATA_W-2:0], tx_q[DATA_W-1]};
            mosi_d = tx_q[DATA_W-2];
          end
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          cnt_d   = '0;
          rx_d    = rxs_q;
          done_d  = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    {ss2_d, ss1_d} = ss_decode(
      (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
      (state_d == ST_HOLD), sel_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rxs_q   <= '0;
      rx_q    <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss1_q   <= 1'b1;
      ss2_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rxs_q   <= rxs_d;
      rx_q    <= rx_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mosi_q  <= mosi_d;
      ss1_q   <= ss1_d;
      ss2_q   <= ss2_d;
    end
  end

endmodule

// File: tb/tb_spi_master_2ss.sv
// Directed bench for spi_master_2ss.
// Default instance with a slave model plus a 16-bit loopback instance.
module tb_spi_master_2ss;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        slave_sel;
  logic [7:0]  tx_data;
  logic        busy, done, sclk, mosi, miso, ss1, ss2;
  logic [7:0]  rx_data;

  logic        start6;
  logic [15:0] tx6, rx6;
  logic        busy6, done6, sclk6, mosi6, ss1_6, ss2_6;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  int nfall = 0, nbase = 0, nrise = 0;
  int ss1_low = 0, ss2_low = 0, sck_hi = 0;
  int done_cnt = 0, both_low = 0;
  logic [7:0] mosi_cap = '0;
  logic [7:0] slv_word = '0;
  int k;

  spi_master_2ss u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .slave_sel (slave_sel),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .ss1       (ss1),
    .ss2       (ss2)
  );

  spi_master_2ss #(.DATA_W(16), .CLK_DIV(2)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start6),
    .slave_sel (1'b0),
    .tx_data   (tx6),
    .busy      (busy6),
    .done      (done6),
    .rx_data   (rx6),
    .sclk      (sclk6),
    .mosi      (mosi6),
    .miso      (mosi6),
    .ss1       (ss1_6),
    .ss2       (ss2_6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge sclk) nfall++;

  always @(posedge sclk) begin
    nrise++;
    mosi_cap = {mosi_cap[6:0], mosi};
  end

  always @(negedge clk) begin
    if (!ss1) ss1_low++;
    if (!ss2) ss2_low++;
    if (!ss1 && !ss2) both_low++;
    if (sclk) sck_hi++;
    if (done) done_cnt++;
  end

  always_comb begin
    k = nfall - nbase;
    miso = 1'b0;
    if (k >= 0 && k < 8) miso = slv_word[7-k];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit six, input int maxc, output int t);
    t = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if ((!six && done) || (six && done6)) begin
        t = cyc;
        break;
      end
    end
    if (t == -1) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic go(input logic sel, input logic [7:0] tx,
                    input logic [7:0] slv, input bit hold,
                    output int acc);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
    slv_word = slv;
    nbase = nfall;
    start = 1'b1;
    slave_sel = sel;
    tx_data = tx;
    @(negedge clk);
    acc = cyc;
    if (!hold) start = 1'b0;
  endtask

  initial begin
    int acc, t, t2, r0, s1b, s2b, hb, dc, gap;
    rst_n = 1'b0;
    start = 1'b0;
    slave_sel = 1'b0;
    tx_data = '0;
    start6 = 1'b0;
    tx6 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ss1", ss1, 1);
    chk("rst_ss2", ss2, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1
    r0 = nrise; s1b = ss1_low; s2b = ss2_low;
    go(1'b0, 8'hA5, 8'h3C, 1'b0, acc);
    chk("t1_busy", busy, 1);
    wait_done(1'b0, 200, t);
    chk("t1_lat", t - acc, 72);
    chk("t1_rx", rx_data, 8'h3C);
    chk("t1_mosi", mosi_cap, 8'hA5);
    chk("t1_rises", nrise - r0, 8);
    chk("t1_ss1low", ss1_low - s1b, 72);
    chk("t1_ss2low", ss2_low - s2b, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    repeat (10) @(negedge clk);

    // T2
    r0 = nrise; s1b = ss1_low; s2b = ss2_low; hb = sck_hi;
    go(1'b1, 8'hFF, 8'h00, 1'b0, acc);
    wait_done(1'b0, 200, t);
    chk("t2_lat", t - acc, 72);
    chk("t2_rx", rx_data, 8'h00);
    chk("t2_ss1low", ss1_low - s1b, 0);
    chk("t2_ss2low", ss2_low - s2b, 72);
    chk("t2_rises", nrise - r0, 8);
    chk("t2_sclk_hi", sck_hi - hb, 32);
    repeat (10) @(negedge clk);

    // T3
    dc = done_cnt; r0 = nrise;
    go(1'b0, 8'hC3, 8'h5A, 1'b0, acc);
    while (cyc < acc + 10) @(negedge clk);
    start = 1'b1; tx_data = 8'h11; slave_sel = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 200, t);
    chk("t3_lat", t - acc, 72);
    chk("t3_rx", rx_data, 8'h5A);
    chk("t3_mosi", mosi_cap, 8'hC3);
    repeat (100) @(negedge clk);
    chk("t3_one_done", done_cnt - dc, 1);
    chk("t3_rises", nrise - r0, 8);
    chk("t3_idle", busy, 0);

    // T4
    go(1'b0, 8'h96, 8'h69, 1'b1, acc);
    wait_done(1'b0, 200, t);
    chk("t4_lat", t - acc, 72);
    chk("t4_rx1", rx_data, 8'h69);
    gap = 0;
    while (ss1 && gap < 20) begin
      gap++;
      @(negedge clk);
    end
    chk("t4_ss_gap", gap >= 4, 1);
    nbase = nfall;
    wait_done(1'b0, 200, t2);
    start = 1'b0;
    chk("t4_spacing", t2 - t, 77);
    chk("t4_rx2", rx_data, 8'h69);
    chk("t4_mosi2", mosi_cap, 8'h96);
    repeat (20) @(negedge clk);
    chk("t4_stopped", busy, 0);

    // T5
    go(1'b1, 8'h5A, 8'hFF, 1'b0, acc);
    dc = done_cnt;
    while (cyc < acc + 30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_ss1", ss1, 1);
    chk("t5_ss2", ss2, 1);
    chk("t5_sclk", sclk, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rx", rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("t5_no_done", done_cnt - dc, 0);
    go(1'b0, 8'h3C, 8'hE7, 1'b0, acc);
    wait_done(1'b0, 200, t);
    chk("t5_lat", t - acc, 72);
    chk("t5_rx2", rx_data, 8'hE7);
    chk("t5_mosi2", mosi_cap, 8'h3C);
    repeat (10) @(negedge clk);

    // T6
    tx6 = 16'h8001;
    start6 = 1'b1;
    @(negedge clk);
    acc = cyc;
    start6 = 1'b0;
    tx6 = 16'h0000;
    wait_done(1'b1, 200, t);
    chk("t6_lat", t - acc, 68);
    chk("t6_rx", rx6, 16'h8001);
    repeat (10) @(negedge clk);
    chk("t6_idle", busy6, 0);

    chk("never_both_low", both_low, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
